// File: rtl/adc_seq_ctrl_if.sv
// Control/status bundle between the SAR ADC sequencer and its host.
// Carries the phase-timing outputs and the frozen clock-gate enables.
interface adc_seq_ctrl_if #(
    parameter int CNT_W  = 8,
    parameter int STEP_W = 5,
    parameter int CONV_W = 16
);
    logic              start;
    logic              cont;
    logic              abort;
    logic [CNT_W-1:0]  init_len;
    logic [CNT_W-1:0]  samp_len;
    logic [CNT_W-1:0]  comp_len;
    logic [CNT_W-1:0]  upd_len;
    logic [STEP_W-1:0] n_steps;
    logic              cfg_en_init;
    logic              cfg_en_samp_p;
    logic              cfg_en_samp_n;
    logic              cfg_en_comp;
    logic              cfg_en_update;

    logic              seq_init;
    logic              seq_samp;
    logic              seq_comp;
    logic              seq_update;
    logic              en_init;
    logic              en_samp_p;
    logic              en_samp_n;
    logic              en_comp;
    logic              en_update;
    logic              busy;
    logic              done;
    logic [CONV_W-1:0] conv_count;

    modport master (
        output start, cont, abort,
        output init_len, samp_len, comp_len, upd_len, n_steps,
        output cfg_en_init, cfg_en_samp_p, cfg_en_samp_n, cfg_en_comp, cfg_en_update,
        input  seq_init, seq_samp, seq_comp, seq_update,
        input  en_init, en_samp_p, en_samp_n, en_comp, en_update,
        input  busy, done, conv_count
    );

    modport slave (
        input  start, cont, abort,
        input  init_len, samp_len, comp_len, upd_len, n_steps,
        input  cfg_en_init, cfg_en_samp_p, cfg_en_samp_n, cfg_en_comp, cfg_en_update,
        output seq_init, seq_samp, seq_comp, seq_update,
        output en_init, en_samp_p, en_samp_n, en_comp, en_update,
        output busy, done, conv_count
    );
endinterface

// File: rtl/adc_seq_ctrl.sv
// SAR ADC conversion sequencer: phase timing plus per-conversion frozen clock-gate enables.
// All outputs are decoded from the next state and registered, so nothing is combinational to the pins.
module adc_seq_ctrl #(
    parameter int CNT_W  = 8,
    parameter int STEP_W = 5,
    parameter int CONV_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    adc_seq_ctrl_if.slave ctrl
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_INIT, S_SAMP, S_COMP, S_UPD, S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_load;
    logic [CNT_W-1:0]  r_samp_len;
    logic [CNT_W-1:0]  r_comp_len;
    logic [CNT_W-1:0]  r_upd_len;
    logic [STEP_W-1:0] r_steps_left;
    logic              w_abort;
    logic              w_phase_end;

    logic w_seq_init, w_seq_samp, w_seq_comp, w_seq_update, w_busy, w_done;
    logic r_seq_init, r_seq_samp, r_seq_comp, r_seq_update, r_busy, r_done;
    logic r_en_init, r_en_samp_p, r_en_samp_n, r_en_comp, r_en_update;
    logic [CONV_W-1:0] r_conv_count;

    // Down-counter preload: a zero length behaves as one cycle, and len-1 never overflows.
    function automatic logic [CNT_W-1:0] len_to_load(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - CNT_W'(1);
    endfunction

    function automatic logic [STEP_W-1:0] eff_steps(input logic [STEP_W-1:0] n);
        return (n == '0) ? STEP_W'(1) : n;
    endfunction

    assign w_abort     = ctrl.abort && (r_state != S_IDLE);
    assign w_phase_end = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (ctrl.start || ctrl.cont) w_next = S_PREP;
            S_PREP: w_next = S_INIT;
            S_INIT: if (w_phase_end) w_next = S_SAMP;
            S_SAMP: if (w_phase_end) w_next = S_COMP;
            S_COMP: if (w_phase_end) w_next = S_UPD;
            S_UPD:  if (w_phase_end) w_next = (r_steps_left <= STEP_W'(1)) ? S_DONE : S_COMP;
            S_DONE: w_next = ctrl.cont ? S_PREP : S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_IDLE;
    end

    always_comb begin
        w_seq_init   = (w_next == S_INIT);
        w_seq_samp   = (w_next == S_SAMP);
        w_seq_comp   = (w_next == S_COMP);
        w_seq_update = (w_next == S_UPD);
        w_busy       = (w_next != S_IDLE);
        w_done       = (w_next == S_DONE);
    end

    // INIT is entered on the PREP exit edge, before the captured lengths are visible.
    always_comb begin
        w_cnt_load = '0;
        case (w_next)
            S_INIT:  w_cnt_load = len_to_load(ctrl.init_len);
            S_SAMP:  w_cnt_load = len_to_load(r_samp_len);
            S_COMP:  w_cnt_load = len_to_load(r_comp_len);
            S_UPD:   w_cnt_load = len_to_load(r_upd_len);
            default: w_cnt_load = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_steps_left <= '0;
        end else begin
            if (w_next != r_state)  r_cnt <= w_cnt_load;
            else if (!w_phase_end)  r_cnt <= r_cnt - CNT_W'(1);

            if (r_state == S_PREP)
                r_steps_left <= eff_steps(ctrl.n_steps);
            else if (r_state == S_UPD && w_next == S_COMP)
                r_steps_left <= r_steps_left - STEP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_PREP) begin
            r_samp_len <= ctrl.samp_len;
            r_comp_len <= ctrl.comp_len;
            r_upd_len  <= ctrl.upd_len;
        end
    end

    // Enables load on PREP entry so they settle a full cycle before any phase rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq_init   <= 1'b0;
            r_seq_samp   <= 1'b0;
            r_seq_comp   <= 1'b0;
            r_seq_update <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_conv_count <= '0;
            r_en_init    <= 1'b0;
            r_en_samp_p  <= 1'b0;
            r_en_samp_n  <= 1'b0;
            r_en_comp    <= 1'b0;
            r_en_update  <= 1'b0;
        end else begin
            r_seq_init   <= w_seq_init;
            r_seq_samp   <= w_seq_samp;
            r_seq_comp   <= w_seq_comp;
            r_seq_update <= w_seq_update;
            r_busy       <= w_busy;
            r_done       <= w_done;
            if (w_done) r_conv_count <= r_conv_count + CONV_W'(1);
            if (w_abort) begin
                r_en_init   <= 1'b0;
                r_en_samp_p <= 1'b0;
                r_en_samp_n <= 1'b0;
                r_en_comp   <= 1'b0;
                r_en_update <= 1'b0;
            end else if (w_next == S_PREP) begin
                r_en_init   <= ctrl.cfg_en_init;
                r_en_samp_p <= ctrl.cfg_en_samp_p;
                r_en_samp_n <= ctrl.cfg_en_samp_n;
                r_en_comp   <= ctrl.cfg_en_comp;
                r_en_update <= ctrl.cfg_en_update;
            end
        end
    end

    assign ctrl.seq_init   = r_seq_init;
    assign ctrl.seq_samp   = r_seq_samp;
    assign ctrl.seq_comp   = r_seq_comp;
    assign ctrl.seq_update = r_seq_update;
    assign ctrl.en_init    = r_en_init;
    assign ctrl.en_samp_p  = r_en_samp_p;
    assign ctrl.en_samp_n  = r_en_samp_n;
    assign ctrl.en_comp    = r_en_comp;
    assign ctrl.en_update  = r_en_update;
    assign ctrl.busy       = r_busy;
    assign ctrl.done       = r_done;
    assign ctrl.conv_count = r_conv_count;

endmodule
